// File: rtl/booth_seq_mul.sv
// booth_seq_mul -- iterative radix-2 Booth multiplier, one Booth step per clock.
//
// Operands are extended to WIDTH+1 bits on acceptance. The extension is sign
// or zero depending on in_signed, so a single signed Booth datapath gives
// exact results in both modes. The block then runs WIDTH+1 add/shift steps
// and presents the low 2*WIDTH bits of {ACC, Q}.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      operand transaction offered (accepted in IDLE only)
//   in_ready      high in IDLE; depends on state only
//   in_signed     1 = two's-complement operands, 0 = unsigned
//   in_a, in_b    multiplicand / multiplier, WIDTH bits each
//   out_valid     out_product holds a completed result (DONE)
//   out_ready     consumer accepts the result
//   out_product   2*WIDTH-bit product; keeps its value until the next result
//   busy          high in CALC or DONE
module booth_seq_mul #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                state_reg, state_next;
  logic [WIDTH:0]        a_ext_reg;
  logic [WIDTH+1:0]      acc_reg;
  logic [WIDTH:0]        q_reg;
  logic                  q_m1_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [2*WIDTH-1:0]    product_reg;

  // The mode bit only matters at the moment of extension, so it is folded
  // into the extended operands instead of being kept in a separate register.
  logic [WIDTH:0]        a_in_ext;
  logic [WIDTH:0]        b_in_ext;

  assign a_in_ext = {in_signed & in_a[WIDTH-1], in_a};
  assign b_in_ext = {in_signed & in_b[WIDTH-1], in_b};

  // One Booth step: conditional add/subtract of A_ext, then arithmetic shift
  // of {ACC, Q, q_-1}. ACC is one bit wider than A_ext, so the sum cannot
  // overflow. A most-negative A is therefore handled by the subtractor itself.
  logic [WIDTH+1:0]      a_addend;
  logic [WIDTH+1:0]      sum;
  logic [WIDTH+1:0]      acc_shift;
  logic [WIDTH:0]        q_shift;
  logic [2*WIDTH-1:0]    product_next;

  always_comb begin
    a_addend = {a_ext_reg[WIDTH], a_ext_reg};
    sum      = acc_reg;
    case ({q_reg[0], q_m1_reg})
      2'b01:   sum = acc_reg + a_addend;
      2'b10:   sum = acc_reg - a_addend;
      default: sum = acc_reg;
    endcase
    acc_shift    = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_shift      = {sum[0], q_reg[WIDTH:1]};
    // Low 2*WIDTH bits of the shifted {ACC, Q}. The bits above them are only
    // sign/guard bits of the extended product.
    product_next = {acc_shift[WIDTH-2:0], q_shift};
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_reg == CNT_ONE) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_ext_reg   <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      q_m1_reg    <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_ext_reg <= a_in_ext;
            q_reg     <= b_in_ext;
            acc_reg   <= '0;
            q_m1_reg  <= 1'b0;
            cnt_reg   <= CNT_START;
          end
        end
        CALC: begin
          acc_reg  <= acc_shift;
          q_reg    <= q_shift;
          q_m1_reg <= q_reg[0];
          cnt_reg  <= cnt_reg - CNT_ONE;
          // The result is captured on the final step. It then holds through
          // DONE and beyond, until the next transaction completes.
          if (cnt_reg == CNT_ONE) product_reg <= product_next;
        end
        default: ;
      endcase
    end
  end

  assign out_product = product_reg;

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul -- scoreboard bench for booth_seq_mul.
// A WIDTH=8 instance covers the directed cases, backpressure and reset abort.
// A WIDTH=4 instance takes an exhaustive back-to-back sweep in both modes.
module tb_booth_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8, s8, or8;
  logic [7:0]  a8, b8;
  logic        ir8, ov8, busy8;
  logic [15:0] p8;

  logic        v4, s4, or4;
  logic [3:0]  a4, b4;
  logic        ir4, ov4, busy4;
  logic [7:0]  p4;

  booth_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(ir8), .in_signed(s8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(or8), .out_product(p8), .busy(busy8)
  );

  booth_seq_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4), .in_ready(ir4), .in_signed(s4), .in_a(a4), .in_b(b4),
    .out_valid(ov4), .out_ready(or4), .out_product(p4), .busy(busy4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] sb8[$];
  logic [7:0]  sb4[$];
  logic [15:0] exp8_mon;
  logic [7:0]  exp4_mon;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitors: pop the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      check("w8_sb_nonempty", 64'(sb8.size() != 0), 64'd1);
      if (sb8.size() != 0) begin
        exp8_mon = sb8.pop_front();
        check("w8_product", 64'(p8), 64'(exp8_mon));
        $display("txn w8 product=%h expected=%h", p8, exp8_mon);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && or4) begin
      check("w4_sb_nonempty", 64'(sb4.size() != 0), 64'd1);
      if (sb4.size() != 0) begin
        exp4_mon = sb4.pop_front();
        check("w4_product", 64'(p4), 64'(exp4_mon));
        $display("txn w4 product=%h expected=%h", p4, exp4_mon);
      end
    end
  end

  // Offer one WIDTH=8 transaction and push its expected product on acceptance.
  // Returns the number of edges from the acceptance edge until out_valid.
  task automatic send8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] e, output int lat);
    int n;
    n = 0;
    while (!ir8 && n < 100) begin @(posedge clk); #1; n++; end
    check("w8_in_ready_wait", 64'(ir8), 64'd1);
    s8 = sg; a8 = a; b8 = b; v8 = 1'b1;
    @(posedge clk);
    sb8.push_back(e);
    #1;
    v8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  function automatic logic [15:0] model8(input logic sg, input logic [7:0] a, input logic [7:0] b);
    if (sg) return 16'(int'($signed(a)) * int'($signed(b)));
    else    return 16'(int'(a) * int'(b));
  endfunction

  function automatic logic [7:0] model4(input logic sg, input logic [3:0] a, input logic [3:0] b);
    if (sg) return 8'(int'($signed(a)) * int'($signed(b)));
    else    return 8'(int'(a) * int'(b));
  endfunction

  initial begin
    int lat;
    int n;
    int last;
    logic seen;
    logic [7:0] ra, rb;
    logic rs;
    logic [3:0] ai, bi;

    rst = 1'b1;
    v8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    v4 = 1'b0; s4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(ir8), 64'd1);
    check("rst_out_valid", 64'(ov8), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_product", 64'(p8), 64'd0);
    check("rst_w4_in_ready", 64'(ir4), 64'd1);
    check("rst_w4_out_valid", 64'(ov4), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed signed/unsigned cases and corners, each with fixed latency.
    send8(1'b1, 8'hFD, 8'h05, 16'hFFF1, lat); check("lat_m3x5", 64'(lat), 64'd9);
    send8(1'b0, 8'hFF, 8'hFF, 16'hFE01, lat); check("lat_uffxff", 64'(lat), 64'd9);
    send8(1'b1, 8'hFF, 8'hFF, 16'h0001, lat); check("lat_sffxff", 64'(lat), 64'd9);
    send8(1'b1, 8'h80, 8'h80, 16'h4000, lat); check("lat_m128sq", 64'(lat), 64'd9);
    send8(1'b1, 8'h7F, 8'h80, 16'hC080, lat); check("lat_127xm128", 64'(lat), 64'd9);
    send8(1'b1, 8'h00, 8'h80, 16'h0000, lat); check("lat_0xm128", 64'(lat), 64'd9);

    // A few random operand pairs against the behavioural model.
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      send8(rs, ra, rb, model8(rs, ra, rb), lat);
      check("lat_rand", 64'(lat), 64'd9);
    end

    // Backpressure: result holds, in_ready stays low, in_valid is ignored.
    @(posedge clk); #1;
    or8 = 1'b0;
    send8(1'b1, 8'h0B, 8'hF9, 16'hFFB3, lat);
    check("lat_bp", 64'(lat), 64'd9);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin v8 = 1'b1; s8 = 1'b0; a8 = 8'h02; b8 = 8'h03; end
      check("bp_out_valid", 64'(ov8), 64'd1);
      check("bp_product", 64'(p8), 64'hFFB3);
      check("bp_in_ready", 64'(ir8), 64'd0);
      @(posedge clk); #1;
    end
    v8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 64'(ov8), 64'd0);
    check("bp_release_in_ready", 64'(ir8), 64'd1);
    check("bp_sb_drained", 64'(sb8.size()), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen = seen | ov8;
      @(posedge clk); #1;
    end
    check("bp_no_extra_result", 64'(seen), 64'd0);

    // Reset in cycle 4 of a transaction aborts it with no output.
    s8 = 1'b0; a8 = 8'h55; b8 = 8'h33; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_busy_before_rst", 64'(busy8), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(ir8), 64'd1);
    check("abort_out_valid", 64'(ov8), 64'd0);
    check("abort_product", 64'(p8), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen = seen | ov8;
      @(posedge clk); #1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    send8(1'b0, 8'd6, 8'd7, 16'h002A, lat);
    check("lat_6x7", 64'(lat), 64'd9);
    @(posedge clk); #1;

    // WIDTH=4: every operand pair in both modes, back to back.
    last = -1;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          ai = 4'(a); bi = 4'(b);
          s4 = 1'(m); a4 = ai; b4 = bi; v4 = 1'b1;
          n = 0;
          while (!ir4 && n < 50) begin @(posedge clk); #1; n++; end
          check("w4_in_ready_wait", 64'(ir4), 64'd1);
          @(posedge clk);
          sb4.push_back(model4(1'(m), ai, bi));
          #1;
          if (last >= 0) check("w4_ii", 64'(cyc - last), 64'd7);
          last = cyc;
        end
      end
    end
    v4 = 1'b0;
    n = 0;
    while (sb4.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("w4_sb_drained", 64'(sb4.size()), 64'd0);
    check("w8_sb_final", 64'(sb8.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
